// File: rtl/sdrc_bs_convert_gen_if.sv
// Request and data signals between the application port, the width converter and the SDRAM core.
// The slave modport is the converter's view; master is the surrounding environment.
interface sdrc_bs_convert_gen_if #(
  parameter int unsigned APP_AW = 30,
  parameter int unsigned APP_DW = 32,
  parameter int unsigned APP_RW = 9,
  parameter int unsigned MAX_RL = 2,
  parameter int unsigned APP_BW = APP_DW / 8
);
  logic                     app_sdr_req;
  logic [APP_AW-1:0]        app_req_addr;
  logic [APP_RW-1:0]        app_req_len;
  logic                     app_req_wr_n;
  logic                     app_req_dma_last;
  logic                     app_req_ack;
  logic                     app_sdr_req_int;
  logic [APP_AW+MAX_RL-1:0] app_req_addr_int;
  logic [APP_RW+MAX_RL-1:0] app_req_len_int;
  logic                     app_req_dma_last_int;
  logic                     app_req_ack_int;
  logic [APP_DW-1:0]        app_wr_data;
  logic [APP_BW-1:0]        app_wr_en_n;
  logic                     app_wr_next;
  logic [APP_DW-1:0]        app_wr_data_int;
  logic [APP_BW-1:0]        app_wr_en_n_int;
  logic                     app_wr_next_int;
  logic [APP_DW-1:0]        app_rd_data_int;
  logic                     app_rd_valid_int;
  logic [APP_DW-1:0]        app_rd_data;
  logic                     app_rd_valid;

  modport slave (
    input  app_sdr_req, app_req_addr, app_req_len, app_req_wr_n, app_req_dma_last,
    input  app_req_ack_int, app_wr_data, app_wr_en_n, app_wr_next_int,
    input  app_rd_data_int, app_rd_valid_int,
    output app_req_ack, app_sdr_req_int, app_req_addr_int, app_req_len_int,
    output app_req_dma_last_int, app_wr_next, app_wr_data_int, app_wr_en_n_int,
    output app_rd_data, app_rd_valid
  );

  modport master (
    output app_sdr_req, app_req_addr, app_req_len, app_req_wr_n, app_req_dma_last,
    output app_req_ack_int, app_wr_data, app_wr_en_n, app_wr_next_int,
    output app_rd_data_int, app_rd_valid_int,
    input  app_req_ack, app_sdr_req_int, app_req_addr_int, app_req_len_int,
    input  app_req_dma_last_int, app_wr_next, app_wr_data_int, app_wr_en_n_int,
    input  app_rd_data, app_rd_valid
  );
endinterface

// File: rtl/sdrc_bs_convert_gen.sv
// Splits application words into 2^r narrow beats for the SDRAM core and reassembles read beats,
// with the ratio r latched per transaction.
module sdrc_bs_convert_gen #(
  parameter int unsigned APP_AW = 30,
  parameter int unsigned APP_DW = 32,
  parameter int unsigned APP_RW = 9,
  parameter int unsigned MAX_RL = 2,
  parameter int unsigned APP_BW = APP_DW / 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          cfg_ratio,
  output logic                cfg_err,
  output logic                busy,
  sdrc_bs_convert_gen_if.slave bus
);

  localparam int unsigned LW  = APP_RW + MAX_RL;
  localparam int unsigned XAW = APP_AW + MAX_RL;

  typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

  state_e            state_q, state_d;
  logic [1:0]        ratio_q, ratio_d;
  logic [LW-1:0]     beats_q, beats_d;
  logic [2:0]        lane_q, lane_d;
  logic [APP_DW-1:0] asm_q, asm_d;
  logic [APP_DW-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic              idle, accept, wr_fire, top_lane;
  logic [2:0]        lane_max;
  logic [LW-1:0]     len_scaled;
  int unsigned       nw, nb, bit_sh, byte_sh;
  logic [APP_DW-1:0] dw_mask, rd_lane;
  logic [APP_BW-1:0] bw_mask;

  assign cfg_err = (32'(cfg_ratio) > MAX_RL);

  // Lane geometry always follows the latched ratio, which is 0 out of reset (pass-through).
  always_comb begin
    idle     = (state_q == StIdle);
    lane_max = 3'((4'd1 << ratio_q) - 4'd1);
    top_lane = (lane_q == lane_max);
    nw       = APP_DW >> ratio_q;
    nb       = APP_BW >> ratio_q;
    bit_sh   = 32'(lane_q) * nw;
    byte_sh  = 32'(lane_q) * nb;
    dw_mask  = {APP_DW{1'b1}} >> (APP_DW - nw);
    bw_mask  = {APP_BW{1'b1}} >> (APP_BW - nb);
    accept   = idle && bus.app_sdr_req && bus.app_req_ack_int;
    wr_fire  = (state_q == StWr) && bus.app_wr_next_int;
    len_scaled = LW'(bus.app_req_len) << cfg_ratio;
    rd_lane  = bus.app_rd_data_int & dw_mask;
  end

  assign busy                     = !idle;
  assign bus.app_sdr_req_int      = idle && bus.app_sdr_req && !cfg_err;
  assign bus.app_req_ack          = idle && bus.app_req_ack_int;
  assign bus.app_req_addr_int     = XAW'(bus.app_req_addr) << cfg_ratio;
  assign bus.app_req_len_int      = len_scaled;
  assign bus.app_req_dma_last_int = bus.app_req_dma_last;
  assign bus.app_wr_data_int      = (bus.app_wr_data >> bit_sh) & dw_mask;
  assign bus.app_wr_en_n_int      = (bus.app_wr_en_n >> byte_sh) | ~bw_mask;
  assign bus.app_wr_next          = wr_fire && top_lane;
  assign bus.app_rd_data          = rd_data_q;
  assign bus.app_rd_valid         = rd_valid_q;

  always_comb begin
    state_d    = state_q;
    ratio_d    = ratio_q;
    beats_d    = beats_q;
    lane_d     = lane_q;
    asm_d      = asm_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          ratio_d = cfg_ratio;
          beats_d = len_scaled;
          lane_d  = 3'd0;
          if (len_scaled != '0) begin
            state_d = bus.app_req_wr_n ? StRd : StWr;
          end
        end
      end
      StWr: begin
        if (bus.app_wr_next_int) begin
          lane_d  = top_lane ? 3'd0 : lane_q + 3'd1;
          beats_d = beats_q - LW'(1);
          if (beats_q == LW'(1)) state_d = StIdle;
        end
      end
      StRd: begin
        if (bus.app_rd_valid_int) begin
          asm_d   = (asm_q & ~(dw_mask << bit_sh)) | (rd_lane << bit_sh);
          lane_d  = top_lane ? 3'd0 : lane_q + 3'd1;
          beats_d = beats_q - LW'(1);
          if (beats_q == LW'(1)) state_d = StIdle;
          // Completed word includes the beat arriving this cycle.
          if (top_lane) begin
            rd_data_d  = asm_d;
            rd_valid_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ratio_q    <= 2'd0;
      beats_q    <= '0;
      lane_q     <= 3'd0;
      asm_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ratio_q    <= ratio_d;
      beats_q    <= beats_d;
      lane_q     <= lane_d;
      asm_q      <= asm_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_sdrc_bs_convert_gen.sv
// Randomized scoreboard bench: the driver pushes expected request, write-lane and read-word
// results computed arithmetically; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_sdrc_bs_convert_gen;
  localparam int unsigned APP_AW = 30;
  localparam int unsigned APP_DW = 32;
  localparam int unsigned APP_RW = 9;
  localparam int unsigned MAX_RL = 2;
  localparam int unsigned APP_BW = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] cfg_ratio;
  logic       cfg_err, busy;

  sdrc_bs_convert_gen_if #(.APP_AW(APP_AW), .APP_DW(APP_DW), .APP_RW(APP_RW),
                           .MAX_RL(MAX_RL), .APP_BW(APP_BW)) bus ();

  sdrc_bs_convert_gen #(.APP_AW(APP_AW), .APP_DW(APP_DW), .APP_RW(APP_RW),
                        .MAX_RL(MAX_RL), .APP_BW(APP_BW)) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_ratio(cfg_ratio),
    .cfg_err  (cfg_err),
    .busy     (busy),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [3:0] en; logic nxt; } wr_exp_t;
  typedef struct { logic [31:0] data; int unsigned cyc; } rd_exp_t;
  typedef struct { logic [31:0] addr; logic [10:0] len; logic dl; } req_exp_t;

  wr_exp_t  wr_q[$];
  rd_exp_t  rd_q[$];
  req_exp_t req_q[$];
  wr_exp_t  mw;
  rd_exp_t  mr;
  req_exp_t mq;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          phase = 0;  // 0 none, 1 write transfer, 2 read transfer
  logic [31:0] last_rd = '0;
  logic [31:0] wr_words[$];
  logic [3:0]  wr_ens[$];
  logic [31:0] rd_beats[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.app_sdr_req_int && bus.app_req_ack_int) begin
        if (req_q.size() == 0) fail_event("unexpected_req");
        else begin
          mq = req_q.pop_front();
          chk("req_addr_int", 64'(bus.app_req_addr_int), 64'(mq.addr));
          chk("req_len_int", 64'(bus.app_req_len_int), 64'(mq.len));
          chk("req_dma_last", 64'(bus.app_req_dma_last_int), 64'(mq.dl));
          chk("req_ack", 64'(bus.app_req_ack), 64'd1);
        end
      end
      if (phase != 0) chk("stall_req", {bus.app_sdr_req_int, bus.app_req_ack}, 64'd0);
      if (phase == 1 && bus.app_wr_next_int) begin
        if (wr_q.size() == 0) fail_event("unexpected_wr_beat");
        else begin
          mw = wr_q.pop_front();
          chk("wr_data_int", 64'(bus.app_wr_data_int), 64'(mw.data));
          chk("wr_en_n_int", 64'(bus.app_wr_en_n_int), 64'(mw.en));
          chk("wr_next", 64'(bus.app_wr_next), 64'(mw.nxt));
        end
      end
      if (phase != 1 && bus.app_wr_next_int) chk("wr_next_ignored", 64'(bus.app_wr_next), 64'd0);
      if (bus.app_rd_valid) begin
        if (rd_q.size() == 0) fail_event("unexpected_rd_valid");
        else begin
          mr = rd_q.pop_front();
          chk("rd_data", 64'(bus.app_rd_data), 64'(mr.data));
          chk("rd_latency_cycle", 64'(cyc), 64'(mr.cyc));
          last_rd = mr.data;
        end
      end else begin
        chk("rd_hold", 64'(bus.app_rd_data), 64'(last_rd));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input bit wr, input int r, input int len, input logic [29:0] addr,
                        input bit gaps, input int reset_after);
    req_exp_t    re;
    wr_exp_t     we;
    rd_exp_t     rexp;
    bit          ok;
    int          beats, lane, idx;
    int unsigned nw, nb, e;
    logic [63:0] acc;
    nw = 32 >> r;
    nb = 4 >> r;
    cfg_ratio            = 2'(r);
    bus.app_req_wr_n     = !wr;
    bus.app_req_addr     = addr;
    bus.app_req_len      = 9'(len);
    bus.app_req_dma_last = 1'($urandom_range(0, 1));
    bus.app_sdr_req      = 1'b1;
    re.addr = 32'(64'(addr) * (64'd1 << r));
    re.len  = 11'(len * (1 << r));
    re.dl   = bus.app_req_dma_last;
    req_q.push_back(re);
    if (wr && len > 0) begin
      bus.app_wr_data = wr_words[0];
      bus.app_wr_en_n = wr_ens[0];
    end
    #1;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (bus.app_sdr_req_int) ok = 1'b1;
      else tick();
    end
    if (!ok) begin
      fail_event("req_forward_timeout");
      bus.app_sdr_req = 1'b0;
      return;
    end
    bus.app_req_ack_int = 1'b1;
    tick();
    bus.app_req_ack_int = 1'b0;
    bus.app_sdr_req     = 1'b0;
    chk("busy_on_accept", 64'(busy), 64'(len > 0));
    beats = len << r;
    if (beats > 0) phase = wr ? 1 : 2;
    lane = 0;
    idx  = 0;
    acc  = '0;
    for (int b = 0; b < beats; b++) begin
      cfg_ratio = 2'($urandom_range(0, 3));
      if (gaps && $urandom_range(0, 2) == 0) begin
        if (wr) begin
          bus.app_rd_valid_int = 1'b1;
          bus.app_rd_data_int  = $urandom;
        end else bus.app_wr_next_int = 1'b1;
        tick();
        bus.app_rd_valid_int = 1'b0;
        bus.app_wr_next_int  = 1'b0;
      end
      if (b == reset_after) begin
        reset   = 1'b1;
        phase   = 0;
        last_rd = '0;
        tick();
        reset = 1'b0;
        return;
      end
      if (b == beats - 1 && $urandom_range(0, 1) == 1) bus.app_sdr_req = 1'b1;
      if (wr) begin
        e       = 32'(wr_ens[idx]);
        we.data = 32'((64'(wr_words[idx]) >> (lane * nw)) % (64'd1 << nw));
        we.en   = 4'(((e >> (lane * nb)) % (1 << nb)) + (16 - (1 << nb)));
        we.nxt  = (lane == (1 << r) - 1);
        wr_q.push_back(we);
        bus.app_wr_next_int = 1'b1;
        tick();
        bus.app_wr_next_int = 1'b0;
        if (we.nxt) begin
          lane = 0;
          idx++;
          if (idx < len) begin
            bus.app_wr_data = wr_words[idx];
            bus.app_wr_en_n = wr_ens[idx];
          end
        end else lane++;
      end else begin
        bus.app_rd_data_int  = rd_beats[b];
        bus.app_rd_valid_int = 1'b1;
        acc = acc + ((64'(rd_beats[b]) % (64'd1 << nw)) << (lane * nw));
        if (lane == (1 << r) - 1) begin
          rexp.data = acc[31:0];
          rexp.cyc  = cyc + 1;
          rd_q.push_back(rexp);
          acc  = '0;
          lane = 0;
        end else lane++;
        tick();
        bus.app_rd_valid_int = 1'b0;
      end
    end
    phase = 0;
  endtask

  task automatic fill(input int len, input int r);
    wr_words.delete();
    wr_ens.delete();
    rd_beats.delete();
    for (int i = 0; i < len; i++) begin
      wr_words.push_back($urandom);
      wr_ens.push_back(4'($urandom));
    end
    for (int i = 0; i < (len << r); i++) rd_beats.push_back($urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, len;
    bus.app_sdr_req      = 1'b1;
    bus.app_req_addr     = '0;
    bus.app_req_len      = '0;
    bus.app_req_wr_n     = 1'b0;
    bus.app_req_dma_last = 1'b0;
    bus.app_req_ack_int  = 1'b1;
    bus.app_wr_data      = 32'h1234_5678;
    bus.app_wr_en_n      = 4'b1010;
    bus.app_wr_next_int  = 1'b1;
    bus.app_rd_data_int  = '0;
    bus.app_rd_valid_int = 1'b0;
    cfg_ratio            = 2'd0;
    tick();
    tick();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rd_valid", 64'(bus.app_rd_valid), 64'd0);
    chk("reset_rd_data", 64'(bus.app_rd_data), 64'd0);
    chk("reset_wr_next", 64'(bus.app_wr_next), 64'd0);
    chk("reset_wr_data_int", 64'(bus.app_wr_data_int), 64'h1234_5678);
    chk("reset_wr_en_n_int", 64'(bus.app_wr_en_n_int), 64'b1010);
    chk("reset_req_int", 64'(bus.app_sdr_req_int), 64'd1);
    chk("reset_req_ack", 64'(bus.app_req_ack), 64'd1);
    bus.app_sdr_req     = 1'b0;
    bus.app_req_ack_int = 1'b0;
    bus.app_wr_next_int = 1'b0;
    reset = 1'b0;
    tick();

    // Ratio 2 write of 0xAABBCCDD words
    fill(4, 1);
    wr_words[0] = 32'hAABB_CCDD;
    do_txn(1'b1, 1, 4, 30'h100, 1'b0, -1);
    chk("busy_after_last_wr", 64'(busy), 64'd0);

    // Ratio 4 read of byte beats 11..88 with garbage above the lane
    fill(2, 2);
    for (int i = 0; i < 8; i++) rd_beats[i] = {24'($urandom), 8'((i + 1) * 8'h11)};
    do_txn(1'b0, 2, 2, 30'h3FFF_FFFF, 1'b1, -1);
    tick();

    // Illegal ratio blocks forwarding
    cfg_ratio       = 2'd3;
    bus.app_sdr_req = 1'b1;
    #1;
    chk("cfg_err_set", 64'(cfg_err), 64'd1);
    chk("cfg_err_req_blocked", 64'(bus.app_sdr_req_int), 64'd0);
    tick();
    chk("cfg_err_req_blocked_later", 64'(bus.app_sdr_req_int), 64'd0);
    cfg_ratio = 2'd2;
    #1;
    chk("cfg_err_clear", 64'(cfg_err), 64'd0);
    chk("req_forward_legal", 64'(bus.app_sdr_req_int), 64'd1);
    bus.app_sdr_req = 1'b0;
    tick();

    // Reset after 3 of 4 read beats, then a fresh read
    fill(1, 2);
    do_txn(1'b0, 2, 1, 30'h55, 1'b0, 3);
    chk("busy_after_reset", 64'(busy), 64'd0);
    chk("rd_data_after_reset", 64'(bus.app_rd_data), 64'd0);
    fill(1, 2);
    do_txn(1'b0, 2, 1, 30'h56, 1'b1, -1);

    // Longest length at ratio 4
    fill(511, 2);
    do_txn(1'b1, 2, 511, 30'h2000, 1'b0, -1);
    chk("busy_after_long_wr", 64'(busy), 64'd0);

    for (int n = 0; n < 40; n++) begin
      r   = $urandom_range(0, MAX_RL);
      len = $urandom_range(0, 5);
      fill(len, r);
      do_txn(1'($urandom_range(0, 1)), r, len, 30'($urandom), 1'b1, -1);
    end
    bus.app_sdr_req = 1'b0;
    repeat (4) tick();
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
    chk("req_q_drained", 64'(req_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdrc_bs_convert_gen.md
Name: sdrc_bs_convert_gen

Overview:
Parametrised bus-width converter between the application request/data interface and the SDRAM core request/data interface. It supports a run-time selectable ratio of 1, 2, 4 or 8 narrow beats per application word. Address and length are widened on the core side, so scaled lengths never truncate. Read data is assembled into a register with a fixed 1-cycle output latency. A per-transaction FSM replaces free-running counters. The block sits between the application port and the SDRAM request/transfer logic.

Parameters:
APP_AW, 30, application address width (word address)
APP_DW, 32, application data width in bits; multiple of 8 and of 2^MAX_RL*8
APP_RW, 9, application request length width (words)
MAX_RL, 2, max log2 ratio supported (0..3)
APP_BW, APP_DW/8, application byte-enable width (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_ratio  in  2  log2 narrow beats per word; legal when <= MAX_RL; sampled at request accept
cfg_err  out  1  high while cfg_ratio > MAX_RL
busy  out  1  high when state != IDLE
app_sdr_req  in  1  application request; held until app_req_ack
app_req_addr  in  APP_AW  word address
app_req_len  in  APP_RW  length in words
app_req_wr_n  in  1  0 = write, 1 = read
app_req_dma_last  in  1  passed through to app_req_dma_last_int
app_req_ack  out  1  equals app_req_ack_int while in IDLE, else 0
app_sdr_req_int  out  1  core request
app_req_addr_int  out  APP_AW+MAX_RL  app_req_addr << cfg_ratio, zero-extended
app_req_len_int  out  APP_RW+MAX_RL  app_req_len << cfg_ratio, zero-extended
app_req_dma_last_int  out  1  pass-through
app_req_ack_int  in  1  core acknowledge
app_wr_data  in  APP_DW  write word
app_wr_en_n  in  APP_BW  active-low byte enables
app_wr_next  out  1  word consumed
app_wr_data_int  out  APP_DW  current narrow lane in LSBs; upper bits zero
app_wr_en_n_int  out  APP_BW  lane enables in LSBs; upper bits 1
app_wr_next_int  in  1  core consumed one narrow beat
app_rd_data_int  in  APP_DW  narrow read beat in LSBs
app_rd_valid_int  in  1  narrow read beat valid
app_rd_data  out  APP_DW  assembled word
app_rd_valid  out  1  1-cycle pulse per assembled word

Behaviour:
- Definitions: NW = APP_DW >> r, where r is the latched ratio. Lane k occupies bits [k*NW +: NW]; lane 0 is the least significant.
- FSM states:
  - IDLE: app_sdr_req_int = app_sdr_req & ~cfg_err.
  - On app_req_ack_int in IDLE (with request high):
    - latch r = cfg_ratio, dir = app_req_wr_n;
    - beats_left = app_req_len << r (width APP_RW+MAX_RL);
    - lane = 0;
    - go to WR or RD; if beats_left == 0, stay in IDLE.
  - WR and RD: app_sdr_req_int = 0; app_req_ack = 0; further requests are stalled.
- WR:
  - app_wr_data_int and app_wr_en_n_int are combinational selects of lane "lane" using the latched r.
  - Each app_wr_next_int: lane increments mod 2^r and beats_left decrements.
  - app_wr_next = app_wr_next_int & (lane == 2^r-1), same cycle.
  - beats_left reaching 0 returns the FSM to IDLE on the next edge.
- RD:
  - Each app_rd_valid_int: lane k of the assembly register <= app_rd_data_int[NW-1:0]; lane increments; beats_left decrements.
  - On the top lane, the next edge sets app_rd_valid = 1 for 1 cycle. app_rd_data = completed word, with the top lane taken from the current beat.
  - app_rd_data holds until the next completed word.
  - Latency: 1 cycle after the last narrow beat, for every ratio including r = 0.
- Outside WR, app_wr_next_int is ignored. Outside RD, app_rd_valid_int is ignored. Neither changes state.
- cfg_ratio changes during a transfer have no effect; the latched r governs the transaction.
- The final beat and a new app_sdr_req in the same cycle: the request is not forwarded that cycle and is forwarded the next cycle at the earliest.
- With r = 0, data and byte enables pass through lane-for-lane, and app_wr_next = app_wr_next_int.
- Reset at any time, including mid-transfer:
  - state = IDLE; beats_left, lane, r and the assembly register = 0; app_rd_data = 0; app_rd_valid = 0;
  - the combinational outputs follow IDLE: app_sdr_req_int = app_sdr_req & ~cfg_err; app_req_ack = app_req_ack_int; app_wr_next = 0;
  - app_wr_data_int = lane-0 select of app_wr_data under r = 0, i.e. app_wr_data; app_wr_en_n_int = app_wr_en_n;
  - a partial read word is discarded.

Test Plan:
- Ratio 2 (r=1), write addr 0x100, len 4 -> addr_int 0x200, len_int 8. For data 0xAABBCCDD: app_wr_data_int 0xCCDD then 0xAABB. 4 app_wr_next pulses, each on odd beats. busy drops after the 8th beat.
- Ratio 4 (r=2), read len 2, byte beats 11,22,33,44,55,66,77,88 -> app_rd_data 0x44332211 then 0x88776655. app_rd_valid pulses 1 cycle after beats 4 and 8.
- APP_RW=9, len 0x1FF, r=2 -> app_req_len_int 0x7FC. No truncation; 2044 beats complete.
- cfg_ratio=3 with MAX_RL=2 -> cfg_err=1. app_sdr_req_int stays 0 with app_sdr_req high.
- Reset after 3 of 4 read beats (r=2) -> busy=0 and no app_rd_valid. A new read completes correctly with fresh data.
- Toggle cfg_ratio mid-write, plus a stray app_rd_valid_int during WR -> lane sequence unchanged and no read output.
